// File: rtl/seg_scan_ctrl.sv
// Dwell-timed 7-segment anode scanner: per digit a dark blank interval followed
// by a lit interval, skipping masked digits, with a pulse on each scan wrap.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 10000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_10Mhz,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS*8-1:0] seg_data,
  output logic [NUM_DIGITS-1:0]   an_sel,
  output logic [7:0]              seg_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  // Polarity is applied only by XOR at the output registers.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [IDX_W-1:0] first_idx_s;
  logic [IDX_W-1:0] next_idx_s;
  logic             end_dwell_s;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] mask);
    lowest_set = {IDX_W{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Next set bit strictly above cur, otherwise wrap to the lowest (cur itself last).
  function automatic logic [IDX_W-1:0] next_set(input logic [NUM_DIGITS-1:0] mask,
                                               input logic [IDX_W-1:0] cur);
    logic             found;
    logic [IDX_W-1:0] above;
    found = 1'b0;
    above = {IDX_W{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) > cur)) begin
        above = IDX_W'(i);
        found = 1'b1;
      end
    end
    next_set = found ? above : lowest_set(mask);
  endfunction

  function automatic logic [NUM_DIGITS-1:0] one_hot(input logic [IDX_W-1:0] idx);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      one_hot[i] = (IDX_W'(i) == idx);
    end
  endfunction

  // Next-digit selection and dwell counter arithmetic.
  always_comb begin
    cnt_inc_s   = cnt_r + CNT_W'(1);
    end_dwell_s = (cnt_r == LAST_CNT);
    first_idx_s = lowest_set(digit_en);
    next_idx_s  = next_set(digit_en, digit_idx);
  end

  // Scan FSM with registered anode, segment, index and wrap outputs.
  always_ff @(posedge clk_10Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      digit_idx  <= {IDX_W{1'b0}};
      frame_tick <= 1'b0;
      an_sel     <= AN_OFF;
      seg_out    <= SEG_OFF;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r      <= {CNT_W{1'b0}};
          frame_tick <= 1'b0;
          an_sel     <= AN_OFF;
          seg_out    <= SEG_OFF;
          if (enable && (|digit_en)) begin
            state_r   <= BLANK;
            digit_idx <= first_idx_s;
          end else begin
            state_r <= IDLE;
          end
        end
        BLANK, SHOW: begin
          if (!enable) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            frame_tick <= 1'b0;
            an_sel     <= AN_OFF;
            seg_out    <= SEG_OFF;
          end else if (end_dwell_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            an_sel  <= AN_OFF;
            seg_out <= SEG_OFF;
            if (digit_en == {NUM_DIGITS{1'b0}}) begin
              state_r    <= IDLE;
              frame_tick <= 1'b0;
            end else begin
              state_r    <= BLANK;
              digit_idx  <= next_idx_s;
              frame_tick <= (next_idx_s <= digit_idx);
            end
          end else begin
            cnt_r      <= cnt_inc_s;
            frame_tick <= 1'b0;
            if (cnt_inc_s >= BLANK_END) begin
              state_r <= SHOW;
              // Anode drops on the next edge if its enable bit is cleared mid-dwell.
              an_sel  <= (one_hot(digit_idx) & digit_en) ^ AN_OFF;
              seg_out <= seg_data[{digit_idx, 3'b000} +: 8] ^ SEG_OFF;
            end else begin
              state_r <= BLANK;
              an_sel  <= AN_OFF;
              seg_out <= SEG_OFF;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {CNT_W{1'b0}};
          frame_tick <= 1'b0;
          an_sel     <= AN_OFF;
          seg_out    <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl with 4 digits, 8-cycle dwell
// and 2-cycle blank, active-low outputs.
module tb_seg_scan_ctrl;

  logic        clk_10Mhz = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b0;
  logic [3:0]  digit_en  = 4'hF;
  logic [31:0] seg_data  = {8'h04, 8'h03, 8'h02, 8'h01};
  logic [3:0]  an_sel;
  logic [7:0]  seg_out;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int passed = 0;
  int total  = 0;

  always #5 clk_10Mhz = ~clk_10Mhz;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .CLK_DIV     (8),
    .BLANK_CYCLES(2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_10Mhz (clk_10Mhz),
    .reset_n   (reset_n),
    .enable    (enable),
    .digit_en  (digit_en),
    .seg_data  (seg_data),
    .an_sel    (an_sel),
    .seg_out   (seg_out),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  typedef struct {
    bit         rst;
    bit         en;
    logic [3:0] den;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] idx;
    bit         tick;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit en, input logic [3:0] den,
                              input logic [3:0] an, input logic [7:0] seg,
                              input logic [1:0] idx, input bit tick);
    vec_t v;
    v.rst = rst; v.en = en; v.den = den;
    v.an = an; v.seg = seg; v.idx = idx; v.tick = tick;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk_10Mhz);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [3:0] an, input logic [7:0] seg,
                           input logic [1:0] idx, input bit tick);
    check({tag, " an_sel"},     32'(an_sel),     32'(an));
    check({tag, " seg_out"},    32'(seg_out),    32'(seg));
    check({tag, " digit_idx"},  32'(digit_idx),  32'(idx));
    check({tag, " frame_tick"}, 32'(frame_tick), 32'(tick));
  endtask

  initial begin
    // Idle after reset with enable low.
    for (int i = 0; i < 3; i++) add(i == 0, 1'b0, 4'hF, 4'hF, 8'hFF, 2'd0, 1'b0);
    // All four digits: 0,1,2,3 then wrap to 0 at cycle 32.
    for (int c = 0; c < 36; c++) begin
      int d;
      bit show;
      d = (c / 8) % 4;
      show = (c % 8) >= 2;
      add(c == 0, 1'b1, 4'hF, show ? 4'hF ^ (4'b0001 << d) : 4'hF,
          show ? 8'hFF ^ 8'(d + 1) : 8'hFF, 2'(d), c == 32);
    end
    // Mask 1010: digits 1 and 3 alternate, wrap 3->1 every 16 cycles.
    for (int c = 0; c < 34; c++) begin
      bit odd;
      bit show;
      odd = ((c / 8) % 2) == 1;
      show = (c % 8) >= 2;
      add(c == 0, 1'b1, 4'b1010, show ? (odd ? 4'b0111 : 4'b1101) : 4'hF,
          show ? (odd ? 8'hFB : 8'hFD) : 8'hFF, odd ? 2'd3 : 2'd1,
          (c > 0) && (c % 16 == 0));
    end
    // Single digit 2: ticks every dwell.
    for (int c = 0; c < 26; c++) begin
      bit show;
      show = (c % 8) >= 2;
      add(c == 0, 1'b1, 4'b0100, show ? 4'b1011 : 4'hF, show ? 8'hFC : 8'hFF,
          2'd2, (c > 0) && (c % 8 == 0));
    end

    #16;
    check_all("post_reset", 4'hF, 8'hFF, 2'd0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulse_reset();
      enable   = vecs[i].en;
      digit_en = vecs[i].den;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].idx, vecs[i].tick);
    end

    // Disable during the third lit cycle of digit 1, then restart from digit 0.
    pulse_reset();
    enable = 1'b1;
    digit_en = 4'hF;
    repeat (13) step();
    check_all("dis_pre", 4'b1101, 8'hFD, 2'd1, 1'b0);
    enable = 1'b0;
    step();
    check("dis_an", 32'(an_sel), 32'(4'hF));
    check("dis_seg", 32'(seg_out), 32'(8'hFF));
    check("dis_tick", 32'(frame_tick), 32'(1'b0));
    step();
    check("dis_idle_an", 32'(an_sel), 32'(4'hF));
    enable = 1'b1;
    step();
    check("reen_blank0_an", 32'(an_sel), 32'(4'hF));
    check("reen_idx", 32'(digit_idx), 32'(2'd0));
    step();
    check("reen_blank1_an", 32'(an_sel), 32'(4'hF));
    step();
    check("reen_show_an", 32'(an_sel), 32'(4'b1110));
    check("reen_show_seg", 32'(seg_out), 32'(8'hFE));

    // Asynchronous reset between edges while a digit is lit.
    pulse_reset();
    repeat (5) step();
    check("arst_pre_an", 32'(an_sel), 32'(4'b1110));
    #2;
    reset_n = 1'b0;
    #1;
    check_all("arst", 4'hF, 8'hFF, 2'd0, 1'b0);
    reset_n = 1'b1;

    // Mask cleared mid-dwell: anode dark, dwell completes, then idle without tick.
    digit_en = 4'b0001;
    pulse_reset();
    repeat (4) step();
    check("clr_pre_an", 32'(an_sel), 32'(4'b1110));
    digit_en = 4'b0000;
    step();
    check("clr_gate_an", 32'(an_sel), 32'(4'hF));
    repeat (3) step();
    check("clr_last_an", 32'(an_sel), 32'(4'hF));
    step();
    check("clr_end_tick", 32'(frame_tick), 32'(1'b0));
    check("clr_end_an", 32'(an_sel), 32'(4'hF));
    digit_en = 4'b0001;
    step();
    check("clr_restart0_an", 32'(an_sel), 32'(4'hF));
    step();
    check("clr_restart1_an", 32'(an_sel), 32'(4'hF));
    step();
    check("clr_restart_show", 32'(an_sel), 32'(4'b1110));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
